// File: rtl/matmul_stream_nxn.sv
// -----------------------------------------------------------------------------
// matmul_stream_nxn
//   Streaming NxN matrix multiplier. Two NxN operand matrices arrive row-major
//   over a valid/ready stream (A first, then B). A single MAC computes one
//   partial product per cycle (N^3 cycles per job) into an NxN result buffer.
//   The buffer is read back by row-major element address through a registered
//   read port.
//
//   Build option: define MATMUL_SIGNED_EN to treat operands and results as
//   two's complement. Ports and timing are the same in both builds.
//
// Ports:
//   clk       in   1       clock, rising edge
//   mr_n      in   1       asynchronous active-low master reset
//   in_valid  in   1       operand beat valid
//   in_ready  out  1       operand beat can be accepted (LOAD_A/LOAD_B/DONE)
//   in_data   in   DATA_W  operand element
//   busy      out  1       computation in progress
//   done      out  1       result buffer holds a complete product
//   out_en    in   1       read enable; low loads 0 into rd_data
//   rd_addr   in   ADDR_W  result index i*N+j
//   rd_data   out  ACC_W   registered result element
// -----------------------------------------------------------------------------
module matmul_stream_nxn #(
    parameter  int N      = 3,
    parameter  int DATA_W = 4,
    localparam int ACC_W  = 2*DATA_W + $clog2(N),
    localparam int ADDR_W = $clog2(N*N)
) (
    input  logic              clk,
    input  logic              mr_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              done,
    input  logic              out_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ACC_W-1:0]  rd_data
);

    localparam int                IDX_W    = $clog2(N);
    localparam int                NN       = N*N;
    localparam logic [ADDR_W-1:0] LAST_LD  = ADDR_W'(NN-1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N-1);
    localparam logic [ADDR_W:0]   NN_W     = (ADDR_W+1)'(NN);

    typedef enum logic [1:0] {
        ST_LOAD_A  = 2'd0,
        ST_LOAD_B  = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // One product, extended to the accumulator width.
    function automatic logic [ACC_W-1:0] mac_product(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] p;
`ifdef MATMUL_SIGNED_EN
        // Sign-extend operands to full product width; low bits are the signed product.
        p = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
        return {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
`else
        p = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        return {{(ACC_W-2*DATA_W){1'b0}}, p};
`endif
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ld_cnt_q, ld_cnt_d;
    logic [IDX_W-1:0]    i_q, i_d, j_q, j_d, k_q, k_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ACC_W-1:0]    rd_data_q, rd_data_d;
    logic [DATA_W-1:0]   a_q [NN];
    logic [DATA_W-1:0]   b_q [NN];
    logic [ACC_W-1:0]    c_q [NN];

    logic                beat_s, a_we_s, b_we_s, c_we_s;
    logic [ADDR_W-1:0]   a_idx_s, b_idx_s, c_idx_s;
    logic [ACC_W-1:0]    mac_sum_s;

    // Operand/result addressing and the MAC adder.
    always_comb begin
        a_idx_s   = ADDR_W'(int'(i_q)*N + int'(k_q));
        b_idx_s   = ADDR_W'(int'(k_q)*N + int'(j_q));
        c_idx_s   = ADDR_W'(int'(i_q)*N + int'(j_q));
        mac_sum_s = acc_q + mac_product(a_q[a_idx_s], b_q[b_idx_s]);
        beat_s    = in_valid && in_ready_q;
    end

    // FSM next state, counters and registered-output next values.
    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        acc_d      = acc_q;
        in_ready_d = in_ready_q;
        busy_d     = busy_q;
        done_d     = done_q;
        a_we_s     = 1'b0;
        b_we_s     = 1'b0;
        c_we_s     = 1'b0;
        case (state_q)
            ST_LOAD_A: begin
                if (beat_s) begin
                    a_we_s = 1'b1;
                    if (ld_cnt_q == LAST_LD) begin
                        ld_cnt_d = {ADDR_W{1'b0}};
                        state_d  = ST_LOAD_B;
                    end else begin
                        ld_cnt_d = ld_cnt_q + ADDR_W'(1);
                    end
                end else begin
                    ld_cnt_d = ld_cnt_q;
                end
            end
            ST_LOAD_B: begin
                if (beat_s) begin
                    b_we_s = 1'b1;
                    if (ld_cnt_q == LAST_LD) begin
                        ld_cnt_d   = {ADDR_W{1'b0}};
                        state_d    = ST_COMPUTE;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b1;
                        i_d        = {IDX_W{1'b0}};
                        j_d        = {IDX_W{1'b0}};
                        k_d        = {IDX_W{1'b0}};
                        acc_d      = {ACC_W{1'b0}};
                    end else begin
                        ld_cnt_d = ld_cnt_q + ADDR_W'(1);
                    end
                end else begin
                    ld_cnt_d = ld_cnt_q;
                end
            end
            ST_COMPUTE: begin
                if (k_q == LAST_IDX) begin
                    // Last term of C[i][j]: commit it and move to the next element.
                    c_we_s = 1'b1;
                    acc_d  = {ACC_W{1'b0}};
                    k_d    = {IDX_W{1'b0}};
                    if (j_q == LAST_IDX) begin
                        j_d = {IDX_W{1'b0}};
                        if (i_q == LAST_IDX) begin
                            i_d        = {IDX_W{1'b0}};
                            state_d    = ST_DONE;
                            in_ready_d = 1'b1;
                            busy_d     = 1'b0;
                            done_d     = 1'b1;
                        end else begin
                            i_d = i_q + IDX_W'(1);
                        end
                    end else begin
                        j_d = j_q + IDX_W'(1);
                    end
                end else begin
                    acc_d = mac_sum_s;
                    k_d   = k_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                // A new job may start straight from DONE; ld_cnt_q is 0 here,
                // so this beat lands in A[0].
                if (beat_s) begin
                    a_we_s   = 1'b1;
                    ld_cnt_d = ADDR_W'(1);
                    done_d   = 1'b0;
                    state_d  = ST_LOAD_A;
                end else begin
                    ld_cnt_d = ld_cnt_q;
                end
            end
            default: begin
                state_d    = ST_LOAD_A;
                ld_cnt_d   = {ADDR_W{1'b0}};
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
                done_d     = 1'b0;
            end
        endcase
    end

    // Registered read port; out-of-range or disabled reads give 0.
    always_comb begin
        if (out_en && ({1'b0, rd_addr} < NN_W)) begin
            rd_data_d = c_q[rd_addr];
        end else begin
            rd_data_d = {ACC_W{1'b0}};
        end
    end

    // State, counters, operand/result storage and output registers.
    always_ff @(posedge clk or negedge mr_n) begin
        if (!mr_n) begin
            state_q    <= ST_LOAD_A;
            ld_cnt_q   <= {ADDR_W{1'b0}};
            i_q        <= {IDX_W{1'b0}};
            j_q        <= {IDX_W{1'b0}};
            k_q        <= {IDX_W{1'b0}};
            acc_q      <= {ACC_W{1'b0}};
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_data_q  <= {ACC_W{1'b0}};
            for (int n = 0; n < NN; n++) begin
                a_q[n] <= {DATA_W{1'b0}};
                b_q[n] <= {DATA_W{1'b0}};
                c_q[n] <= {ACC_W{1'b0}};
            end
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
            if (a_we_s) begin
                a_q[ld_cnt_q] <= in_data;
            end
            if (b_we_s) begin
                b_q[ld_cnt_q] <= in_data;
            end
            if (c_we_s) begin
                c_q[c_idx_s] <= mac_sum_s;
            end
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;

endmodule
